spi_flash_rd_seq: RTL and testbench

APB-master sequencer that sits directly upstream of the CoreSPI flash-interface subsystem and drives its APB slave port to fetch a contiguous block from serial flash. It issues a READ command, a 24-bit address and dummy frames one frame at a time through the CoreSPI TX/RX data registers, with a poll on status between frames. Each received data byte goes out on a valid/ready byte stream for downstream consumers, such as a DDR loader or a checksum engine.

---
 rtl/spi_flash_rd_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_flash_rd_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: APB master that walks CoreSPI through a serial-flash READ.
// It sends opcode, 24-bit address and dummy frames one at a time, polls status
// between frames, and streams every data byte out on a valid/ready interface.
// Build option: define SPI_FLASH_RD_FAST_EN to use FAST READ (opcode 0x0B)
// with one extra discarded dummy frame in the header.
module spi_flash_rd_seq #(
    parameter int POLL_MAX = 1023
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [23:0] rd_addr,
    input  logic [15:0] rd_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [6:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    // CoreSPI register map; CONTROL (0x00) is left at its power-on setup.
    localparam logic [6:0] ADDR_RXDATA = 7'h08;
    localparam logic [6:0] ADDR_TXDATA = 7'h0C;
    localparam logic [6:0] ADDR_STATUS = 7'h20;
    localparam logic [6:0] ADDR_SSEL   = 7'h24;
    localparam int         RXEMPTY_BIT = 2;

`ifdef SPI_FLASH_RD_FAST_EN
    localparam logic [7:0]  OPCODE = 8'h0B;
    localparam logic [16:0] HDR    = 17'd5;
`else
    localparam logic [7:0]  OPCODE = 8'h03;
    localparam logic [16:0] HDR    = 17'd4;
`endif

    // Poll counter only needs to reach POLL_MAX-1 before the timeout decision.
    localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SKIP,
        S_SS_ON,
        S_TX,
        S_POLL,
        S_RX,
        S_EMIT,
        S_SS_OFF,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic            access, access_n;
    logic [23:0]     addr_q, addr_n;
    logic [15:0]     len_q, len_n;
    logic [16:0]     frame_idx, frame_n;
    logic [PCW-1:0]  poll_cnt, poll_n;
    logic            aborted, aborted_n;
    logic            load_data;
    logic            step_frame;
    logic            abort_now;
    logic            xfer_done;
    logic [16:0]     last_idx;
    logic [7:0]      frame_byte;
    logic            unused_prdata;

    assign last_idx      = {1'b0, len_q} + HDR - 17'd1;
    assign unused_prdata = ^PRDATA[31:8];

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE) && !aborted;
    assign err       = (state == S_DONE) && aborted;
    assign out_valid = (state == S_EMIT);

    // Pick the byte to shift out for the current frame: opcode, address, then dummies.
    always_comb begin
        frame_byte = 8'h00;
        case (frame_idx)
            17'd0:   frame_byte = OPCODE;
            17'd1:   frame_byte = addr_q[23:16];
            17'd2:   frame_byte = addr_q[15:8];
            17'd3:   frame_byte = addr_q[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    // State, transfer phase and per-request context registers; reset abandons any command.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= S_IDLE;
            access    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            frame_idx <= '0;
            poll_cnt  <= '0;
            aborted   <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            access    <= access_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            frame_idx <= frame_n;
            poll_cnt  <= poll_n;
            aborted   <= aborted_n;
            if (load_data) begin
                out_data <= PRDATA[7:0];
            end
        end
    end

    // Next-state logic and APB drive; each bus state is one SETUP then ACCESS until PREADY.
    always_comb begin
        state_n    = state;
        access_n   = access;
        addr_n     = addr_q;
        len_n      = len_q;
        frame_n    = frame_idx;
        poll_n     = poll_cnt;
        aborted_n  = aborted;
        load_data  = 1'b0;
        step_frame = 1'b0;
        abort_now  = 1'b0;
        xfer_done  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = '0;
        PWDATA     = '0;

        if (state inside {S_SS_ON, S_TX, S_POLL, S_RX, S_SS_OFF}) begin
            PSEL      = 1'b1;
            PENABLE   = access;
            xfer_done = access && PREADY;
            access_n  = access ? !PREADY : 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_n    = rd_addr;
                    len_n     = rd_len;
                    frame_n   = '0;
                    poll_n    = '0;
                    aborted_n = 1'b0;
                    access_n  = 1'b0;
                    state_n   = (rd_len == 16'd0) ? S_SKIP : S_SS_ON;
                end
            end
            S_SKIP: begin
                state_n = S_DONE;
            end
            S_SS_ON: begin
                PWRITE = 1'b1;
                PADDR  = ADDR_SSEL;
                PWDATA = 32'h1;
                if (xfer_done) begin
                    if (PSLVERR) abort_now = 1'b1;
                    else         state_n   = S_TX;
                end
            end
            S_TX: begin
                PWRITE = 1'b1;
                PADDR  = ADDR_TXDATA;
                PWDATA = {24'h0, frame_byte};
                if (xfer_done) begin
                    if (PSLVERR) begin
                        abort_now = 1'b1;
                    end else begin
                        poll_n  = '0;
                        state_n = S_POLL;
                    end
                end
            end
            S_POLL: begin
                PADDR = ADDR_STATUS;
                if (xfer_done) begin
                    if (PSLVERR) begin
                        abort_now = 1'b1;
                    end else if (!PRDATA[RXEMPTY_BIT]) begin
                        state_n = S_RX;
                    end else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                        abort_now = 1'b1;
                    end else begin
                        poll_n = poll_cnt + 1'b1;
                    end
                end
            end
            S_RX: begin
                PADDR = ADDR_RXDATA;
                if (xfer_done) begin
                    if (PSLVERR) begin
                        abort_now = 1'b1;
                    end else if (frame_idx < HDR) begin
                        step_frame = 1'b1;
                    end else begin
                        load_data = 1'b1;
                        state_n   = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) step_frame = 1'b1;
            end
            S_SS_OFF: begin
                PWRITE = 1'b1;
                PADDR  = ADDR_SSEL;
                PWDATA = 32'h0;
                if (xfer_done) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (abort_now) begin
            aborted_n = 1'b1;
            state_n   = S_SS_OFF;
        end

        if (step_frame) begin
            if (frame_idx == last_idx) begin
                state_n = S_SS_OFF;
            end else begin
                frame_n = frame_idx + 17'd1;
                state_n = S_TX;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: directed bench for spi_flash_rd_seq with a small CoreSPI
// APB slave model (wait states, RXEMPTY polls, PSLVERR injection) and logs of
// every completed transfer and streamed byte.
module tb_spi_flash_rd_seq;

    localparam logic [6:0] ADDR_RXDATA = 7'h08;
    localparam logic [6:0] ADDR_TXDATA = 7'h0C;
    localparam logic [6:0] ADDR_STATUS = 7'h20;
    localparam logic [6:0] ADDR_SSEL   = 7'h24;
`ifdef SPI_FLASH_RD_FAST_EN
    localparam logic [7:0] EXP_OPC = 8'h0B;
    localparam int         EXP_HDR = 5;
`else
    localparam logic [7:0] EXP_OPC = 8'h03;
    localparam int         EXP_HDR = 4;
`endif

    logic        PCLK;
    logic        PRESET;
    logic        start;
    logic [23:0] rd_addr;
    logic [15:0] rd_len;
    logic        busy, done, err;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        PSEL, PENABLE, PWRITE;
    logic [6:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    int          wait_states, empty_polls, err_tx_idx;
    logic [7:0]  rx_data [0:3];
    logic        model_clear;

    int          wait_cnt, tx_cnt, ssel_cnt, status_reads, rx_reads, xfer_cnt;
    int          poll_in_frame, done_cnt, err_cnt, valid_cycles, stream_cnt, psel_cycles;
    logic [7:0]  tx_log    [0:31];
    logic [31:0] ssel_log  [0:7];
    logic [6:0]  xfer_addr [0:63];
    logic [7:0]  stream    [0:15];

    int          checks, errors;
    int          cyc, n, bad;

    spi_flash_rd_seq #(.POLL_MAX(4)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign PREADY  = PSEL && PENABLE && (wait_cnt >= wait_states);
    assign PSLVERR = PREADY && PWRITE && (PADDR == ADDR_TXDATA) && (tx_cnt == err_tx_idx);

    // Slave read data: RXEMPTY for the first empty_polls reads of a frame, junk for header RX.
    always_comb begin
        PRDATA = 32'h0;
        if (PADDR == ADDR_STATUS) begin
            PRDATA = (poll_in_frame < empty_polls) ? 32'h4 : 32'h0;
        end else if (PADDR == ADDR_RXDATA) begin
            if (rx_reads < EXP_HDR)              PRDATA = 32'h5A;
            else if (rx_reads - EXP_HDR < 4)     PRDATA = {24'h0, rx_data[rx_reads - EXP_HDR]};
        end
    end

    // Slave bookkeeping and output monitors, all sampled on the active edge.
    always @(posedge PCLK) begin
        if (model_clear) begin
            wait_cnt <= 0; tx_cnt <= 0; ssel_cnt <= 0; status_reads <= 0; rx_reads <= 0;
            xfer_cnt <= 0; poll_in_frame <= 0; done_cnt <= 0; err_cnt <= 0;
            valid_cycles <= 0; stream_cnt <= 0; psel_cycles <= 0;
        end else begin
            if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
            else                            wait_cnt <= 0;
            if (PSEL) psel_cycles <= psel_cycles + 1;
            if (PSEL && PENABLE && PREADY) begin
                if (xfer_cnt < 64) xfer_addr[xfer_cnt] <= PADDR;
                xfer_cnt <= xfer_cnt + 1;
                if (PADDR == ADDR_TXDATA) begin
                    if (tx_cnt < 32) tx_log[tx_cnt] <= PWDATA[7:0];
                    tx_cnt <= tx_cnt + 1;
                    poll_in_frame <= 0;
                end else if (PADDR == ADDR_STATUS) begin
                    status_reads <= status_reads + 1;
                    poll_in_frame <= poll_in_frame + 1;
                end else if (PADDR == ADDR_RXDATA) begin
                    rx_reads <= rx_reads + 1;
                end else if (PADDR == ADDR_SSEL) begin
                    if (ssel_cnt < 8) ssel_log[ssel_cnt] <= PWDATA;
                    ssel_cnt <= ssel_cnt + 1;
                end
            end
            if (done) done_cnt <= done_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (out_valid) valid_cycles <= valid_cycles + 1;
            if (out_valid && out_ready) begin
                if (stream_cnt < 16) stream[stream_cnt] <= out_data;
                stream_cnt <= stream_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] a, input logic [15:0] l);
        @(negedge PCLK);
        rd_addr = a;
        rd_len  = l;
        start   = 1'b1;
        @(negedge PCLK);
        start   = 1'b0;
    endtask

    task automatic clearModel();
        @(negedge PCLK);
        model_clear = 1'b1;
        @(negedge PCLK);
        model_clear = 1'b0;
    endtask

    task automatic waitForEnd(input int first, input int maxc, output int c);
        c = first;
        while (!(done || err) && c < maxc) begin
            @(negedge PCLK);
            c++;
        end
        checkOutput("end_seen", done || err, 1);
    endtask

    task automatic checkRead(input string pfx, input int len, input int cyc_obs, input int cyc_exp);
        logic [63:0] so, se;
        int nz;
        checkOutput({pfx, "_cycles"}, cyc_obs, cyc_exp);
        checkOutput({pfx, "_tx_cnt"}, tx_cnt, EXP_HDR + len);
        checkOutput({pfx, "_tx_hdr"}, {tx_log[0], tx_log[1], tx_log[2], tx_log[3]},
                    {EXP_OPC, rd_addr[23:16], rd_addr[15:8], rd_addr[7:0]});
        nz = 0;
        for (int i = 4; i < tx_cnt && i < 32; i++) if (tx_log[i] != 8'h00) nz++;
        checkOutput({pfx, "_tx_dummy"}, nz, 0);
        checkOutput({pfx, "_ssel_cnt"}, ssel_cnt, 2);
        checkOutput({pfx, "_ssel_vals"}, {ssel_log[0], ssel_log[1]}, 64'h00000001_00000000);
        checkOutput({pfx, "_stream_cnt"}, stream_cnt, len);
        so = '0; se = '0;
        for (int i = 0; i < len && i < 4; i++) begin
            so = (so << 8) | {56'h0, stream[i]};
            se = (se << 8) | {56'h0, rx_data[i]};
        end
        checkOutput({pfx, "_stream"}, so, se);
        checkOutput({pfx, "_done_err"}, {done_cnt[7:0], err_cnt[7:0]}, 16'h0100);
    endtask

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        PRESET = 1'b1; start = 1'b0; rd_addr = '0; rd_len = '0; out_ready = 1'b1;
        wait_states = 0; empty_polls = 0; err_tx_idx = -1; model_clear = 1'b1;
        rx_data[0] = 8'hAA; rx_data[1] = 8'hBB; rx_data[2] = 8'hCC; rx_data[3] = 8'hDD;
        repeat (3) @(negedge PCLK);
        checkOutput("reset_vals",
                    {busy, done, err, out_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, out_data},
                    '0);
        PRESET = 1'b0;
        model_clear = 1'b0;

        // Basic read: 3 bytes from 0x012345, zero wait states.
        $display("[TB] basic read");
        clearModel();
        applyStimulus(24'h012345, 16'd3);
        checkOutput("sson_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy},
                    {1'b1, 1'b0, 1'b1, ADDR_SSEL, 32'h1, 1'b1});
        @(negedge PCLK);
        checkOutput("sson_access", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                    {1'b1, 1'b1, 1'b1, ADDR_SSEL, 32'h1});
        waitForEnd(2, 400, cyc);
        checkOutput("basic_end_flags", {done, err, busy}, 3'b100);
        repeat (3) @(negedge PCLK);
        checkRead("basic", 3, cyc, 6 * (EXP_HDR + 3) + 3 + 5);
        checkOutput("basic_valid_cycles", valid_cycles, 3);

        // Backpressure: hold out_ready low for 10 cycles on the second byte.
        $display("[TB] backpressure");
        clearModel();
        applyStimulus(24'h012345, 16'd3);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge PCLK); n++; end
        checkOutput("bp_first_valid", out_valid, 1);
        @(negedge PCLK);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge PCLK); n++; end
        checkOutput("bp_second_data", {out_valid, out_data}, {1'b1, 8'hBB});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(out_valid === 1'b1 && out_data === 8'hBB && PSEL === 1'b0)) bad++;
            @(negedge PCLK);
        end
        checkOutput("bp_stall_stable", bad, 0);
        out_ready = 1'b1;
        waitForEnd(0, 400, cyc);
        repeat (3) @(negedge PCLK);
        checkOutput("bp_stream_cnt", stream_cnt, 3);
        checkOutput("bp_stream", {stream[0], stream[1], stream[2]}, 24'hAABBCC);
        checkOutput("bp_valid_cycles", valid_cycles, 13);
        checkOutput("bp_done_err", {done_cnt[7:0], err_cnt[7:0]}, 16'h0100);

        // Poll timeout: RXEMPTY never clears, POLL_MAX is 4.
        $display("[TB] poll timeout");
        clearModel();
        empty_polls = 1000;
        applyStimulus(24'h012345, 16'd3);
        waitForEnd(1, 200, cyc);
        checkOutput("to_end_flags", {done, err, busy}, 3'b010);
        checkOutput("to_cycles", cyc, 15);
        repeat (3) @(negedge PCLK);
        checkOutput("to_status_reads", status_reads, 4);
        checkOutput("to_xfers", {xfer_cnt[7:0], xfer_addr[5], xfer_addr[6]},
                    {8'd7, ADDR_STATUS, ADDR_SSEL});
        checkOutput("to_ssel_vals", {ssel_cnt[7:0], ssel_log[1]}, {8'd2, 32'h0});
        checkOutput("to_done_err", {done_cnt[7:0], err_cnt[7:0], valid_cycles[7:0]}, 24'h000100);
        empty_polls = 0;

        // Slave error on the third TXDATA write with 2 wait states everywhere.
        $display("[TB] slave error");
        clearModel();
        wait_states = 2;
        err_tx_idx = 2;
        applyStimulus(24'h012345, 16'd3);
        waitForEnd(1, 400, cyc);
        checkOutput("se_end_flags", {done, err, busy}, 3'b010);
        checkOutput("se_cycles", cyc, 37);
        repeat (3) @(negedge PCLK);
        checkOutput("se_xfers", {xfer_cnt[7:0], xfer_addr[7], xfer_addr[8]},
                    {8'd9, ADDR_TXDATA, ADDR_SSEL});
        checkOutput("se_counts", {tx_cnt[7:0], status_reads[7:0], rx_reads[7:0]}, 24'h030202);
        checkOutput("se_ssel_off", ssel_log[1], 32'h0);
        checkOutput("se_no_valid", valid_cycles, 0);
        checkOutput("se_done_err", {done_cnt[7:0], err_cnt[7:0]}, 16'h0001);
        wait_states = 0;
        err_tx_idx = -1;

        // Zero length: done two cycles after start, no bus activity.
        $display("[TB] zero length");
        clearModel();
        applyStimulus(24'h000100, 16'd0);
        checkOutput("z_cycle1", {busy, done, err, PSEL}, 4'b1000);
        @(negedge PCLK);
        checkOutput("z_cycle2", {busy, done, err, PSEL}, 4'b0100);
        repeat (3) @(negedge PCLK);
        checkOutput("z_no_apb", psel_cycles, 0);
        checkOutput("z_done_cnt", done_cnt, 1);

        // Reset during the POLL of frame 5, then a full read afterwards.
        $display("[TB] reset mid-read");
        clearModel();
        empty_polls = 2;
        applyStimulus(24'h012345, 16'd3);
        n = 0;
        while (!(tx_cnt == 6 && PSEL && PADDR == ADDR_STATUS) && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("rst_reached_poll5", {PSEL, PADDR}, {1'b1, ADDR_STATUS});
        PRESET = 1'b1;
        #1;
        checkOutput("rst_async", {PSEL, PENABLE, busy, out_valid}, 4'b0000);
        @(negedge PCLK);
        PRESET = 1'b0;
        empty_polls = 0;
        clearModel();
        applyStimulus(24'h012345, 16'd3);
        waitForEnd(1, 400, cyc);
        repeat (3) @(negedge PCLK);
        checkRead("post_rst", 3, cyc, 6 * (EXP_HDR + 3) + 3 + 5);

        // Two-byte read; a start pulse while busy must be ignored.
        $display("[TB] two-byte read");
        clearModel();
        applyStimulus(24'hABCDEF, 16'd2);
        rd_len = 16'd5;
        start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
        rd_addr = 24'hABCDEF;
        waitForEnd(2, 400, cyc);
        repeat (3) @(negedge PCLK);
        checkRead("len2", 2, cyc, 6 * (EXP_HDR + 2) + 2 + 5);
        checkOutput("len2_rx_reads", rx_reads, EXP_HDR + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
